pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage core. It generates the stall and bubble controls for the regF/regD/regE/regM/regW pipeline registers from load-use, data-memory-wait, instruction-fetch-wait and execute-redirect conditions. It tracks outstanding waits in a small FSM with a memory-timeout watchdog and provides stall and flush performance counters. It sits beside the datapath and drives every `*_stall`/`*_bubble` input in the pipeline.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_if.sv | 47 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 56 +++++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: types and constants shared by the hazard controller.
//   state_e  - hazard FSM states
//   ctrl_t   - stall/bubble bundle driven into the pipeline registers
//   REG_X0   - index of the hard-wired zero register
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic e_stall;
        logic m_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_bubble;
    } ctrl_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam ctrl_t CTRL_NONE = '0;

    // While in reset every pipeline register is flushed and nothing is held.
    localparam ctrl_t CTRL_RESET = '{f_stall: 1'b0, d_stall: 1'b0, e_stall: 1'b0, m_stall: 1'b0,
                                     d_bubble: 1'b1, e_bubble: 1'b1, m_bubble: 1'b1, w_bubble: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the datapath and stall/bubble
// controls back to it.
//   master - datapath side: drives hazard sources, receives controls
//   slave  - hazard controller side
interface pipe_hazard_ctrl_if;
    logic [4:0]  regD_i_rs1;
    logic [4:0]  regD_i_rs2;
    logic        regD_i_rs1_used;
    logic        regD_i_rs2_used;
    logic [4:0]  regE_i_rd;
    logic        regE_i_reg_wen;
    logic        regE_i_is_load;
    logic        execute_i_redirect;
    logic        regM_i_mem_access;
    logic        dmem_ready;
    logic        ifetch_busy;
    logic        regF_stall;
    logic        regD_stall;
    logic        regE_stall;
    logic        regM_stall;
    logic        regD_bubble;
    logic        regE_bubble;
    logic        regM_bubble;
    logic        regW_bubble;
    logic        redirect_fire;
    logic        mem_timeout;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;

    modport master (
        output regD_i_rs1, regD_i_rs2, regD_i_rs1_used, regD_i_rs2_used,
               regE_i_rd, regE_i_reg_wen, regE_i_is_load, execute_i_redirect,
               regM_i_mem_access, dmem_ready, ifetch_busy,
        input  regF_stall, regD_stall, regE_stall, regM_stall,
               regD_bubble, regE_bubble, regM_bubble, regW_bubble,
               redirect_fire, mem_timeout, perf_stall_cycles, perf_flush_count
    );

    modport slave (
        input  regD_i_rs1, regD_i_rs2, regD_i_rs1_used, regD_i_rs2_used,
               regE_i_rd, regE_i_reg_wen, regE_i_is_load, execute_i_redirect,
               regM_i_mem_access, dmem_ready, ifetch_busy,
        output regF_stall, regD_stall, regE_stall, regM_stall,
               regD_bubble, regE_bubble, regM_bubble, regW_bubble,
               redirect_fire, mem_timeout, perf_stall_cycles, perf_flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use detection and prioritised
// stall/bubble generation.
//   inputs : decode sources, execute destination/load flags, redirect,
//            mem_stall, ifetch_busy, flush_wait (FSM in FLUSH_WAIT)
//   outputs: ctrl_o bundle, redirect_fire_o
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    input  logic [4:0] rd_i,
    input  logic       reg_wen_i,
    input  logic       is_load_i,
    input  logic       redirect_i,
    input  logic       mem_stall_i,
    input  logic       ifetch_busy_i,
    input  logic       flush_wait_i,
    output ctrl_t      ctrl_o,
    output logic       redirect_fire_o
);

    logic load_use;
    logic fire;

    assign load_use = is_load_i & reg_wen_i & (rd_i != REG_X0) &
                      ((rs1_used_i & (rs1_i == rd_i)) | (rs2_used_i & (rs2_i == rd_i)));

    // A redirect seen during a memory wait stays parked in the stalled regE.
    assign fire = redirect_i & ~mem_stall_i;
    assign redirect_fire_o = fire;

    always_comb begin
        // NOTE: defaulting every output first keeps this block free of latches.
        ctrl_o = CTRL_NONE;
        if (mem_stall_i) begin
            ctrl_o.f_stall  = 1'b1;
            ctrl_o.d_stall  = 1'b1;
            ctrl_o.e_stall  = 1'b1;
            ctrl_o.m_stall  = 1'b1;
            ctrl_o.w_bubble = 1'b1;
        end else if (fire) begin
            ctrl_o.d_bubble = 1'b1;
            ctrl_o.e_bubble = 1'b1;
        end else if (load_use) begin
            ctrl_o.f_stall  = 1'b1;
            ctrl_o.d_stall  = 1'b1;
            ctrl_o.e_bubble = 1'b1;
        end else if (flush_wait_i | ifetch_busy_i) begin
            ctrl_o.f_stall  = 1'b1;
            ctrl_o.d_bubble = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard controller for the five-stage core.
//   clk, rst_n - core clock, asynchronous active-low reset
//   hz (slave) - hazard sources in; stall/bubble/redirect controls,
//                sticky mem_timeout and perf counters out
// Holds the wait FSM, the data-memory watchdog and the perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 1024
) (
    input logic              clk,
    input logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      perf_stall_q, perf_stall_d;
    logic [31:0]      perf_flush_q, perf_flush_d;

    logic  mem_stall;
    ctrl_t ctrl;
    ctrl_t ctrl_out;
    logic  fire;

    assign mem_stall = hz.regM_i_mem_access & ~hz.dmem_ready;

    hazard_detect u_detect (
        .rs1_i           (hz.regD_i_rs1),
        .rs2_i           (hz.regD_i_rs2),
        .rs1_used_i      (hz.regD_i_rs1_used),
        .rs2_used_i      (hz.regD_i_rs2_used),
        .rd_i            (hz.regE_i_rd),
        .reg_wen_i       (hz.regE_i_reg_wen),
        .is_load_i       (hz.regE_i_is_load),
        .redirect_i      (hz.execute_i_redirect),
        .mem_stall_i     (mem_stall),
        .ifetch_busy_i   (hz.ifetch_busy),
        .flush_wait_i    (state_q == ST_FLUSH_WAIT),
        .ctrl_o          (ctrl),
        .redirect_fire_o (fire)
    );

    // Reset overrides the controls combinationally so the pipeline is
    // flushed the moment rst_n falls, without waiting for a clock.
    assign ctrl_out = rst_n ? ctrl : CTRL_RESET;

    assign hz.regF_stall        = ctrl_out.f_stall;
    assign hz.regD_stall        = ctrl_out.d_stall;
    assign hz.regE_stall        = ctrl_out.e_stall;
    assign hz.regM_stall        = ctrl_out.m_stall;
    assign hz.regD_bubble       = ctrl_out.d_bubble;
    assign hz.regE_bubble       = ctrl_out.e_bubble;
    assign hz.regM_bubble       = ctrl_out.m_bubble;
    assign hz.regW_bubble       = ctrl_out.w_bubble;
    assign hz.redirect_fire     = fire & rst_n;
    assign hz.mem_timeout       = timeout_q;
    assign hz.perf_stall_cycles = perf_stall_q;
    assign hz.perf_flush_count  = perf_flush_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    // The first stalled cycle already counts as a wait cycle.
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end else if (fire & hz.ifetch_busy) begin
                    state_d = ST_FLUSH_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_FLUSH_WAIT: begin
                // A memory stall freezes the pipe but the wrong-path fetch is
                // still outstanding, so stay here until both have cleared.
                if (!mem_stall && !hz.ifetch_busy) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (wait_cnt_d == CNT_MAX) begin
            timeout_d = 1'b1;
        end
    end

    assign perf_stall_d = perf_stall_q + 32'(ctrl.f_stall);
    assign perf_flush_d = perf_flush_q + 32'(fire);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed stimulus for pipe_hazard_ctrl with a
// behavioural reference model checked every falling edge, plus literal
// expectations at key points of each scenario.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Controls packed as {F,D,E,M stall, D,E,M,W bubble, redirect_fire}.
    bit          m_flush;      // wrong-path fetch still to be discarded
    int          m_run;        // consecutive data-memory wait cycles
    bit          m_to;
    int unsigned m_stalls;
    int unsigned m_flushes;

    function automatic logic [8:0] dut_ctrl();
        return {hz.regF_stall, hz.regD_stall, hz.regE_stall, hz.regM_stall,
                hz.regD_bubble, hz.regE_bubble, hz.regM_bubble, hz.regW_bubble,
                hz.redirect_fire};
    endfunction

    always @(negedge clk) begin
        logic [8:0] exp;
        bit ms, lu, fire, busy;
        if (!rst_n) begin
            m_flush = 0; m_run = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
            check("model_ctrl_rst", 32'(dut_ctrl()), 32'(9'b0000_1111_0));
            check("model_perf_stall_rst", hz.perf_stall_cycles, 0);
            check("model_timeout_rst", 32'(hz.mem_timeout), 0);
        end else begin
            ms   = hz.regM_i_mem_access && !hz.dmem_ready;
            busy = hz.ifetch_busy;
            lu   = hz.regE_i_is_load && hz.regE_i_reg_wen && hz.regE_i_rd != 0 &&
                   ((hz.regD_i_rs1_used && hz.regD_i_rs1 == hz.regE_i_rd) ||
                    (hz.regD_i_rs2_used && hz.regD_i_rs2 == hz.regE_i_rd));
            fire = hz.execute_i_redirect && !ms;
            if (ms)                   exp = 9'b1111_0001_0;
            else if (fire)            exp = 9'b0000_1100_1;
            else if (lu)              exp = 9'b1100_0100_0;
            else if (m_flush || busy) exp = 9'b1000_1000_0;
            else                      exp = 9'b0;
            check("model_ctrl", 32'(dut_ctrl()), 32'(exp));
            check("model_timeout", 32'(hz.mem_timeout), 32'(m_to));
            check("model_perf_stall", hz.perf_stall_cycles, m_stalls);
            check("model_perf_flush", hz.perf_flush_count, m_flushes);
            // Advance the model to what the next rising edge must produce.
            m_stalls  += exp[8];
            m_flushes += fire;
            if (m_flush) begin
                if (!ms && !busy) m_flush = 0;
            end else begin
                if (m_run == 0 && !ms && fire && busy) m_flush = 1;
                m_run = ms ? m_run + 1 : 0;
                if (m_run >= TIMEOUT) m_to = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        hz.regD_i_rs1 = 0; hz.regD_i_rs2 = 0;
        hz.regD_i_rs1_used = 0; hz.regD_i_rs2_used = 0;
        hz.regE_i_rd = 0; hz.regE_i_reg_wen = 0; hz.regE_i_is_load = 0;
        hz.execute_i_redirect = 0; hz.regM_i_mem_access = 0;
        hz.dmem_ready = 0; hz.ifetch_busy = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2);
        hz.regE_i_is_load = 1; hz.regE_i_reg_wen = 1; hz.regE_i_rd = rd;
        hz.regD_i_rs1 = rs1; hz.regD_i_rs1_used = u1;
        hz.regD_i_rs2 = rs2; hz.regD_i_rs2_used = u2;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        clear_inputs();
        #3;
        check("rst_regD_bubble", 32'(hz.regD_bubble), 1);
        check("rst_regM_bubble", 32'(hz.regM_bubble), 1);
        check("rst_regF_stall", 32'(hz.regF_stall), 0);
        check("rst_perf_stall", hz.perf_stall_cycles, 0);
        cyc();
        rst_n = 1'b1;

        // Load-use via rs1: one stall cycle, then clear once the load moves on.
        set_load(5'd5, 5'd5, 1, 5'd3, 1);
        #1;
        check("lu_stall", 32'({hz.regF_stall, hz.regD_stall, hz.regE_bubble}), 32'(3'b111));
        cyc();
        clear_inputs();
        #1;
        check("lu_after", 32'({hz.regF_stall, hz.regD_stall, hz.regE_bubble}), 0);
        check("lu_perf", hz.perf_stall_cycles, 1);
        // x0 destination never stalls; rs2 match stalls only when used.
        set_load(5'd0, 5'd0, 1, 5'd0, 1);
        #1;
        check("lu_x0", 32'(hz.regF_stall), 0);
        set_load(5'd7, 5'd1, 1, 5'd7, 1);
        #1;
        check("lu_rs2", 32'(hz.regE_bubble), 1);
        set_load(5'd7, 5'd1, 1, 5'd7, 0);
        #1;
        check("lu_rs2_unused", 32'(hz.regE_bubble), 0);
        cyc();

        // Memory wait of 3 cycles with a load-use hazard hidden behind it.
        do_reset();
        hz.regM_i_mem_access = 1;
        set_load(5'd9, 5'd9, 1, 5'd0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("mw_stall", 32'({hz.regF_stall, hz.regD_stall, hz.regE_stall,
                                  hz.regM_stall, hz.regW_bubble, hz.regE_bubble}), 32'(6'b111110));
            cyc();
        end
        hz.dmem_ready = 1;
        #1;
        check("mw_then_lu", 32'({hz.regM_stall, hz.regE_stall, hz.regE_bubble, hz.regF_stall}),
              32'(4'b0011));
        check("mw_perf", hz.perf_stall_cycles, 3);
        cyc();
        clear_inputs();

        // Redirect raised during a memory wait fires once the wait ends.
        do_reset();
        hz.regM_i_mem_access = 1;
        hz.execute_i_redirect = 1;
        #1;
        check("rd_held", 32'(hz.redirect_fire), 0);
        cyc();
        cyc();
        hz.dmem_ready = 1;
        #1;
        check("rd_fire", 32'({hz.redirect_fire, hz.regD_bubble, hz.regE_bubble, hz.regF_stall}),
              32'(4'b1110));
        cyc();
        clear_inputs();
        #1;
        check("rd_flush_cnt", hz.perf_flush_count, 1);
        check("rd_stall_cnt", hz.perf_stall_cycles, 2);

        // Redirect while the fetch is busy for two more cycles.
        do_reset();
        hz.execute_i_redirect = 1;
        hz.ifetch_busy = 1;
        #1;
        check("fw_fire", 32'({hz.redirect_fire, hz.regD_bubble, hz.regE_bubble}), 32'(3'b111));
        cyc();
        hz.execute_i_redirect = 0;
        #1;
        check("fw_wait1", 32'({hz.regF_stall, hz.regD_bubble, hz.regE_bubble}), 32'(3'b110));
        cyc();
        cyc();
        hz.ifetch_busy = 0;
        #1;
        check("fw_drop_stale", 32'({hz.regF_stall, hz.regD_bubble}), 32'(2'b11));
        cyc();
        check("fw_run", 32'({hz.regF_stall, hz.regD_bubble}), 0);
        check("fw_flush_cnt", hz.perf_flush_count, 1);
        check("fw_stall_cnt", hz.perf_stall_cycles, 3);

        // Watchdog: 10 wait cycles, timeout sets after the 8th and sticks.
        do_reset();
        hz.regM_i_mem_access = 1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            check("wd_timeout", 32'(hz.mem_timeout), 32'(k >= TIMEOUT));
        end
        hz.dmem_ready = 1;
        cyc();
        check("wd_stall_cnt", hz.perf_stall_cycles, 10);
        clear_inputs();
        cyc();
        check("wd_sticky", 32'(hz.mem_timeout), 1);

        // Async reset in the middle of FLUSH_WAIT.
        hz.execute_i_redirect = 1;
        hz.ifetch_busy = 1;
        cyc();
        hz.execute_i_redirect = 0;
        #1;
        check("ar_in_flush", 32'(hz.regD_bubble), 1);
        rst_n = 1'b0;
        #1;
        check("ar_bubbles", 32'({hz.regD_bubble, hz.regE_bubble, hz.regM_bubble, hz.regW_bubble}),
              32'(4'b1111));
        check("ar_stalls", 32'({hz.regF_stall, hz.regD_stall, hz.regE_stall, hz.regM_stall,
                               hz.redirect_fire}), 0);
        check("ar_flush_cnt", hz.perf_flush_count, 0);
        check("ar_timeout", 32'(hz.mem_timeout), 0);
        cyc();
        rst_n = 1'b1;
        hz.ifetch_busy = 0;
        #1;
        check("ar_run", 32'(hz.regD_bubble), 0);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
